sweep_scheduler: RTL and testbench

//  Sequences one lighthouse frame: measures the all-sensor sync pulse and decodes its width into skip/data/axis.

---
 rtl/sweep_scheduler.sv | 170 +++++++++++++++++
 tb/tb_sweep_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
//==============================================================================
// sweep_scheduler: lighthouse frame sequencer (sync decode, capture window,
// publish with data_ready/ack handshake).          Revision: 1.0
//==============================================================================
`default_nettype none

module sweep_scheduler #(
  parameter int NSENS     = 4,
  parameter int CNT_W     = 19,
  parameter int SYNC_BASE = 3125,
  parameter int SYNC_STEP = 521,
  parameter int SWEEP_LEN = 400000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic [NSENS-1:0] sens_ready,
  input  logic             host_busy,
  input  logic             host_ack,
  output logic             mask_en,
  output logic             cap_clr,
  output logic             latch,
  output logic             data_ready,
  output logic             axis,
  output logic             ootx_bit,
  output logic             ootx_valid,
  output logic [NSENS-1:0] hit_mask,
  output logic [7:0]       frame_cnt,
  output logic             overrun,
  output logic             sync_err
);

  localparam int T_LO = SYNC_BASE - SYNC_STEP / 2;
  localparam int T_HI = SYNC_BASE + 7 * SYNC_STEP - SYNC_STEP / 2 + SYNC_STEP;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(SWEEP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    SWEEP = 2'd2,
    PUB   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             sync_d;
  logic             sync_rise;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] sweep_cnt;
  logic             dec_axis;
  int               width_i;
  logic [2:0]       k;
  logic             dec_err;
  logic             start_meas;
  logic             decode_evt;
  logic             publish;

  assign sync_rise = sync_in & ~sync_d;
  assign width_i   = int'(width_cnt);

  // k is the highest code whose lower threshold the measured width reaches
  always_comb begin
    k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (width_i >= SYNC_BASE + i * SYNC_STEP - SYNC_STEP / 2) k = 3'(i);
    end
  end

  assign dec_err = (width_i < T_LO) || (width_i >= T_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_meas = 1'b0;
    decode_evt = 1'b0;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (sync_rise) begin
          state_nxt  = MEAS;
          start_meas = 1'b1;
        end
      end
      MEAS: begin
        if (!sync_in) begin
          decode_evt = 1'b1;
          state_nxt  = (dec_err || k[2]) ? IDLE : SWEEP;
        end
      end
      SWEEP: begin
        if (sync_rise) begin
          state_nxt  = MEAS;
          start_meas = 1'b1;
        end else if (sweep_cnt == SWEEP_END) begin
          state_nxt = PUB;
        end
      end
      PUB: begin
        if (!host_busy) begin
          publish   = 1'b1;
          state_nxt = IDLE;
        end else if (sync_rise) begin
          state_nxt  = MEAS;
          start_meas = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mask_en = (state == SWEEP);
  assign latch   = publish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d     <= 1'b0;
      width_cnt  <= '0;
      sweep_cnt  <= '0;
      dec_axis   <= 1'b0;
      cap_clr    <= 1'b0;
      sync_err   <= 1'b0;
      ootx_valid <= 1'b0;
      ootx_bit   <= 1'b0;
      hit_mask   <= '0;
      axis       <= 1'b0;
      frame_cnt  <= 8'd0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_d <= sync_in;

      if (start_meas)
        width_cnt <= CNT_ONE;
      else if (state == MEAS && sync_in && width_cnt != CNT_MAX)
        width_cnt <= width_cnt + CNT_ONE;

      if (state != SWEEP)
        sweep_cnt <= '0;
      else if (sweep_cnt != CNT_MAX)
        sweep_cnt <= sweep_cnt + CNT_ONE;

      cap_clr    <= decode_evt && !dec_err && !k[2];
      sync_err   <= decode_evt && dec_err;
      ootx_valid <= decode_evt && !dec_err;
      if (decode_evt && !dec_err) begin
        ootx_bit <= k[1];
        dec_axis <= k[0];
      end

      // A publish in the same cycle as host_ack keeps data_ready set
      if (publish) begin
        hit_mask   <= sens_ready;
        axis       <= dec_axis;
        frame_cnt  <= frame_cnt + 8'd1;
        data_ready <= 1'b1;
        if (data_ready) overrun <= 1'b1;
      end else if (host_ack) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sweep_scheduler.sv
// Directed testbench for sweep_scheduler with a shortened sweep window.
`default_nettype none

module tb_sweep_scheduler;

  localparam int SL = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_in = 1'b0;
  logic [3:0] sens_ready = 4'd0;
  logic       host_busy = 1'b0;
  logic       host_ack = 1'b0;
  logic       mask_en, cap_clr, latch, data_ready, axis, ootx_bit, ootx_valid;
  logic       overrun, sync_err;
  logic [3:0] hit_mask;
  logic [7:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int n_mask = 0, n_latch = 0, n_clr = 0, n_err = 0, n_ootx = 0;
  int b_mask, b_latch, b_clr, b_err, b_ootx;
  int w3 [4] = '{1000, 8000, 2864, 7033};

  always #5 clk = ~clk;

  sweep_scheduler #(
    .NSENS(4), .CNT_W(19), .SYNC_BASE(3125), .SYNC_STEP(521), .SWEEP_LEN(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .sens_ready(sens_ready),
    .host_busy(host_busy), .host_ack(host_ack), .mask_en(mask_en),
    .cap_clr(cap_clr), .latch(latch), .data_ready(data_ready), .axis(axis),
    .ootx_bit(ootx_bit), .ootx_valid(ootx_valid), .hit_mask(hit_mask),
    .frame_cnt(frame_cnt), .overrun(overrun), .sync_err(sync_err)
  );

  always @(negedge clk) begin
    n_mask  += int'(mask_en);
    n_latch += int'(latch);
    n_clr   += int'(cap_clr);
    n_err   += int'(sync_err);
    n_ootx  += int'(ootx_valid);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sync(input int w);
    sync_in = 1'b1;
    tick(w);
    sync_in = 1'b0;
  endtask

  task automatic pulse_ack();
    host_ack = 1'b1;
    tick(1);
    host_ack = 1'b0;
  endtask

  task automatic snap();
    b_mask = n_mask; b_latch = n_latch; b_clr = n_clr; b_err = n_err; b_ootx = n_ootx;
  endtask

  initial begin
    tick(3);
    check("rst_mask_en", 32'(mask_en), 0);
    check("rst_data_ready", 32'(data_ready), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_latch", 32'(latch), 0);
    rst_n = 1'b1;
    tick(2);

    // frame with k=0, no hits
    snap();
    send_sync(3125);
    tick(1);
    check("t1_cap_clr", 32'(cap_clr), 1);
    check("t1_mask_on", 32'(mask_en), 1);
    check("t1_ootx_valid", 32'(ootx_valid), 1);
    check("t1_ootx_bit", 32'(ootx_bit), 0);
    tick(SL - 1);
    check("t1_mask_last", 32'(mask_en), 1);
    check("t1_no_early_latch", 32'(latch), 0);
    tick(1);
    check("t1_latch", 32'(latch), 1);
    check("t1_mask_off", 32'(mask_en), 0);
    tick(1);
    check("t1_data_ready", 32'(data_ready), 1);
    check("t1_axis", 32'(axis), 0);
    check("t1_frame_cnt", 32'(frame_cnt), 1);
    check("t1_hit_mask", 32'(hit_mask), 0);
    check("t1_mask_cycles", 32'(n_mask - b_mask), SL);
    check("t1_latch_count", 32'(n_latch - b_latch), 1);
    check("t1_clr_count", 32'(n_clr - b_clr), 1);

    // skip codes: k=5 and k=7 (upper edge)
    snap();
    send_sync(5730);
    tick(1);
    check("t2_ootx_valid", 32'(ootx_valid), 1);
    check("t2_ootx_bit", 32'(ootx_bit), 0);
    check("t2_no_clr", 32'(cap_clr), 0);
    tick(SL + 5);
    send_sync(7032);
    tick(1);
    check("t2_k7_valid", 32'(ootx_valid), 1);
    check("t2_k7_bit", 32'(ootx_bit), 1);
    check("t2_k7_err", 32'(sync_err), 0);
    tick(SL + 5);
    check("t2_mask_cycles", 32'(n_mask - b_mask), 0);
    check("t2_latch_count", 32'(n_latch - b_latch), 0);
    check("t2_clr_count", 32'(n_clr - b_clr), 0);

    // out-of-range widths
    snap();
    for (int i = 0; i < 4; i++) begin
      send_sync(w3[i]);
      tick(1);
      check($sformatf("t3_err_w%0d", w3[i]), 32'(sync_err), 1);
      check($sformatf("t3_nootx_w%0d", w3[i]), 32'(ootx_valid), 0);
      tick(3);
    end
    check("t3_err_count", 32'(n_err - b_err), 4);
    check("t3_ootx_count", 32'(n_ootx - b_ootx), 0);
    check("t3_clr_count", 32'(n_clr - b_clr), 0);

    // k=1 with host busy at sweep end
    pulse_ack();
    check("t4_ack_clears", 32'(data_ready), 0);
    host_busy = 1'b1;
    send_sync(3646);
    tick(1);
    check("t4_cap_clr", 32'(cap_clr), 1);
    tick(SL);
    check("t4_busy_no_latch", 32'(latch), 0);
    snap();
    tick(1000);
    check("t4_wait_latches", 32'(n_latch - b_latch), 0);
    host_busy = 1'b0;
    #1;
    check("t4_latch", 32'(latch), 1);
    tick(1);
    check("t4_axis", 32'(axis), 1);
    check("t4_frame_cnt", 32'(frame_cnt), 2);
    check("t4_overrun", 32'(overrun), 0);
    check("t4_latch_count", 32'(n_latch - b_latch), 1);

    // sync rise while waiting in publish drops the frame
    pulse_ack();
    host_busy = 1'b1;
    send_sync(3646);
    tick(1);
    tick(SL + 10);
    snap();
    send_sync(3125);
    tick(1);
    check("t4b_remeas_clr", 32'(cap_clr), 1);
    check("t4b_dropped", 32'(n_latch - b_latch), 0);
    host_busy = 1'b0;
    tick(SL);
    check("t4b_latch", 32'(latch), 1);
    tick(1);
    check("t4b_frame_cnt", 32'(frame_cnt), 3);
    check("t4b_axis", 32'(axis), 0);
    check("t4b_latch_count", 32'(n_latch - b_latch), 1);

    // overrun and ack/latch collision
    pulse_ack();
    check("t5_ack_clears", 32'(data_ready), 0);
    sens_ready = 4'b1010;
    send_sync(4000);
    tick(1);
    check("t5_ootx_bit1", 32'(ootx_bit), 1);
    tick(SL);
    check("t5_latch1", 32'(latch), 1);
    tick(1);
    check("t5_hit_mask1", 32'(hit_mask), 4'ha);
    check("t5_overrun0", 32'(overrun), 0);
    sens_ready = 4'b0101;
    send_sync(3125);
    tick(SL + 2);
    check("t5_overrun1", 32'(overrun), 1);
    check("t5_frame_cnt", 32'(frame_cnt), 5);
    check("t5_hit_mask2", 32'(hit_mask), 4'h5);
    pulse_ack();
    check("t5_ack_dr", 32'(data_ready), 0);
    check("t5_sticky", 32'(overrun), 1);
    send_sync(3646);
    tick(SL + 1);
    check("t5_latch3", 32'(latch), 1);
    host_ack = 1'b1;
    tick(1);
    host_ack = 1'b0;
    check("t5_latch_wins", 32'(data_ready), 1);
    check("t5_frame_cnt3", 32'(frame_cnt), 6);

    // async reset mid-sweep, then restart at the lower width edge
    send_sync(3125);
    tick(100);
    check("t6_in_sweep", 32'(mask_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_mask", 32'(mask_en), 0);
    check("t6_rst_dr", 32'(data_ready), 0);
    check("t6_rst_fc", 32'(frame_cnt), 0);
    check("t6_rst_ovr", 32'(overrun), 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    send_sync(2865);
    tick(1);
    check("t6_cap_clr", 32'(cap_clr), 1);
    tick(SL);
    check("t6_latch", 32'(latch), 1);
    tick(1);
    check("t6_frame_cnt", 32'(frame_cnt), 1);
    check("t6_data_ready", 32'(data_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
